// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI write-channel arbiter and its helpers.
package axi_arb_pkg;
  typedef enum logic [1:0] {IDLE, AW, W, B} arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_wr_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after last_i, wrapping to 0.
// Purely combinational, zero latency; no backpressure.
module rr_pick import axi_arb_pkg::*; #(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  always_comb begin
    gnt_oh_o = '0;
    idx_o    = '0;
    vld_o    = 1'b0;
    // Two passes: indices above last first, then wrap around to the rest.
    for (int i = 0; i < N; i++) begin
      if (!vld_o && req_i[i] && (IW'(i) > last_i)) begin
        gnt_oh_o[i] = 1'b1;
        idx_o       = IW'(i);
        vld_o       = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!vld_o && req_i[i] && (IW'(i) <= last_i)) begin
        gnt_oh_o[i] = 1'b1;
        idx_o       = IW'(i);
        vld_o       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_wr_arbiter.sv
// Shares one AXI4 write channel among NUM_M masters, one whole AW/W/B transaction at a time, round-robin.
// Grant 1 cycle after AWVALID in IDLE; payload is combinational; non-owners and early W see ready low.
module axi_wr_arbiter import axi_arb_pkg::*; #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [NUM_M-1:0]          m_awvalid,
  output logic [NUM_M-1:0]          m_awready,
  input  logic [NUM_M*ADDR_W-1:0]   m_awaddr,
  input  logic [NUM_M*8-1:0]        m_awlen,
  input  logic [NUM_M-1:0]          m_wvalid,
  output logic [NUM_M-1:0]          m_wready,
  input  logic [NUM_M*DATA_W-1:0]   m_wdata,
  input  logic [NUM_M*DATA_W/8-1:0] m_wstrb,
  input  logic [NUM_M-1:0]          m_wlast,
  output logic [NUM_M-1:0]          m_bvalid,
  input  logic [NUM_M-1:0]          m_bready,
  output logic [NUM_M*2-1:0]        m_bresp,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [ADDR_W-1:0]         s_awaddr,
  output logic [7:0]                s_awlen,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wstrb,
  output logic                      s_wlast,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  input  logic [1:0]                s_bresp,
  output logic [NUM_M-1:0]          grant,
  output logic                      busy
);
  localparam int IW = idx_w(NUM_M);
  localparam int SW = DATA_W / 8;

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    gnt_idx_q, gnt_idx_d;
  logic [IW-1:0]    last_q, last_d;
  logic [NUM_M-1:0] gnt_oh_q, gnt_oh_d;

  logic [NUM_M-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;

  rr_pick #(.N(NUM_M), .IW(IW)) u_pick (
    .req_i    (m_awvalid),
    .last_i   (last_q),
    .gnt_oh_o (pick_oh),
    .idx_o    (pick_idx),
    .vld_o    (pick_vld)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      last_q    <= IW'(NUM_M - 1);
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_oh_q  <= gnt_oh_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    gnt_oh_d  = gnt_oh_q;
    last_d    = last_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d   = AW;
        gnt_idx_d = pick_idx;
        gnt_oh_d  = pick_oh;
      end
      AW: if (s_awvalid && s_awready) state_d = W;
      // WLAST alone closes the burst; AWLEN is only forwarded.
      W:  if (s_wvalid && s_wready && s_wlast) state_d = B;
      B:  if (s_bvalid && s_bready) begin
        state_d  = IDLE;
        gnt_oh_d = '0;
        last_d   = gnt_idx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_awvalid = (state_q == AW) && m_awvalid[gnt_idx_q];
    s_awaddr  = m_awaddr[int'(gnt_idx_q)*ADDR_W +: ADDR_W];
    s_awlen   = m_awlen[int'(gnt_idx_q)*8 +: 8];
    s_wvalid  = (state_q == W) && m_wvalid[gnt_idx_q];
    s_wdata   = m_wdata[int'(gnt_idx_q)*DATA_W +: DATA_W];
    s_wstrb   = m_wstrb[int'(gnt_idx_q)*SW +: SW];
    s_wlast   = m_wlast[gnt_idx_q];
    s_bready  = (state_q == B) && m_bready[gnt_idx_q];
    m_awready = gnt_oh_q & {NUM_M{(state_q == AW) && s_awready}};
    m_wready  = gnt_oh_q & {NUM_M{(state_q == W) && s_wready}};
    m_bvalid  = gnt_oh_q & {NUM_M{(state_q == B) && s_bvalid}};
    m_bresp   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_oh_q[i]) m_bresp[i*2 +: 2] = s_bresp;
    end
    grant = gnt_oh_q;
    busy  = (state_q != IDLE);
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: two master models, one slave model, per-scenario checks.
module tb_axi_wr_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ARESETn;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [63:0] m_awaddr, m_wdata;
  logic [15:0] m_awlen;
  logic [7:0]  m_wstrb;
  logic [3:0]  m_bresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_bvalid, s_bready;
  logic        s_wready = 1'b1;
  logic [31:0] s_awaddr, s_wdata;
  logic [7:0]  s_awlen;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, grant;
  logic        busy;

  axi_wr_arbiter #(.NUM_M(2), .ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(clk), .ARESETn(ARESETn),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .grant(grant), .busy(busy)
  );

  // Stimulus configuration, written only by the test sequence.
  int         req_cnt[2] = '{0, 0};
  logic       early[2]   = '{1'b0, 1'b0};
  logic [7:0] len_cfg[2] = '{8'd0, 8'd0};
  logic       w_toggle   = 1'b0;
  int         b_delay    = 0;
  logic [1:0] bresp_val  = 2'b00;

  // Model state and logs, written only by the monitor.
  int          done_cnt[2] = '{0, 0};
  int          phase[2]    = '{0, 0};
  int          beat[2]     = '{0, 0};
  int          cyc = 0, gcyc = 0, b_wait = 0, w_wait = 0, viol = 0, b_cnt = 0;
  logic        b_pend = 1'b0;
  logic [1:0]  grant_prev = 2'b00;
  logic [31:0] wq[$];
  logic [31:0] aq[$];
  logic [1:0]  gq[$];
  logic [2:0]  brq[$];
  int          g_edge_q[$];
  int          b_edge_q[$];

  int checks = 0, errors = 0;

  function automatic logic [31:0] data_of(input int m, input int k, input int bt);
    return 32'hD000_0000 | (32'(m) << 20) | (32'(k) << 8) | 32'(bt);
  endfunction

  // Drive all DUT inputs away from the active edge.
  always @(negedge clk) begin : drv
    logic act;
    for (int m = 0; m < 2; m++) begin
      act = done_cnt[m] < req_cnt[m];
      m_awvalid[m]         = act && (phase[m] == 0);
      m_awaddr[m*32 +: 32] = 32'h1000 + 32'(m << 12) + 32'(done_cnt[m] << 4);
      m_awlen[m*8 +: 8]    = len_cfg[m];
      m_wvalid[m]          = act && ((phase[m] == 1) || ((phase[m] == 0) && early[m]));
      m_wdata[m*32 +: 32]  = data_of(m, done_cnt[m], beat[m]);
      m_wstrb[m*4 +: 4]    = 4'hF;
      m_wlast[m]           = (beat[m] == int'(len_cfg[m]));
      m_bready[m]          = act && (phase[m] == 2);
    end
    s_awready = 1'b1;
    s_wready  = w_toggle ? ~s_wready : 1'b1;
    s_bvalid  = b_pend && (b_cnt == 0);
    s_bresp   = bresp_val;
  end

  always @(posedge clk) begin
    cyc++;
    if (!ARESETn) begin
      for (int m = 0; m < 2; m++) begin
        phase[m] = 0; beat[m] = 0; done_cnt[m] = req_cnt[m];
      end
      b_pend = 1'b0; b_cnt = 0; grant_prev = 2'b00;
    end else begin
      if (grant != 2'b00) gcyc++;
      if (grant != 2'b00 && grant_prev == 2'b00) g_edge_q.push_back(cyc);
      grant_prev = grant;
      if (s_awvalid && s_awready) begin gq.push_back(grant); aq.push_back(s_awaddr); end
      if (s_wvalid && !s_wready) w_wait++;
      if (s_bready && !s_bvalid) b_wait++;
      if (b_pend && b_cnt > 0) b_cnt--;
      if (s_wvalid && s_wready) begin
        wq.push_back(s_wdata);
        if (s_wlast) begin b_pend = 1'b1; b_cnt = b_delay; end
      end
      if (s_bvalid && s_bready) begin b_pend = 1'b0; b_edge_q.push_back(cyc); end
      for (int m = 0; m < 2; m++) begin
        if (m_wready[m] && (!grant[m] || phase[m] != 1)) viol++;
        if (m_awvalid[m] && m_awready[m]) phase[m] = 1;
        if (m_wvalid[m] && m_wready[m]) begin
          if (m_wlast[m]) phase[m] = 2; else beat[m]++;
        end
        if (m_bvalid[m] && m_bready[m]) begin
          brq.push_back({1'(m), m_bresp[m*2 +: 2]});
          phase[m] = 0; beat[m] = 0; done_cnt[m]++;
        end
      end
    end
  end

  task automatic wait_idle(input int t0, input int t1, input int limit, output logic ok);
    int n = 0;
    while ((done_cnt[0] < t0 || done_cnt[1] < t1) && n < limit) begin
      @(posedge clk); n++;
    end
    #2;
    ok = (done_cnt[0] >= t0) && (done_cnt[1] >= t1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2; ARESETn = 1'b0;
    @(posedge clk); #2; ARESETn = 1'b1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({s_awvalid, s_wvalid, s_bready} !== 3'b000) begin errors++; $display("FAIL reset_slave_side: got %b expected 000", {s_awvalid, s_wvalid, s_bready}); end
    checks++; if ({m_awready, m_wready, m_bvalid} !== 6'b0) begin errors++; $display("FAIL reset_master_side: got %b expected 000000", {m_awready, m_wready, m_bvalid}); end
    @(posedge clk); #2; ARESETn = 1'b1;
  endtask

  task automatic test_single();
    int wb, bb, g0, bw0, k0; logic ok;
    @(posedge clk); #2;
    wb = wq.size(); bb = brq.size(); g0 = gcyc; bw0 = b_wait; k0 = done_cnt[0];
    len_cfg[0] = 8'd3; bresp_val = 2'b00; req_cnt[0]++;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_pre_grant: got %b expected 00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", grant); end
    checks++; if ({s_awvalid, busy} !== 2'b11) begin errors++; $display("FAIL single_awvalid_busy: got %b expected 11", {s_awvalid, busy}); end
    checks++; if (s_awaddr !== 32'h1000 || s_awlen !== 8'd3) begin errors++; $display("FAIL single_aw_payload: got %h/%0d expected 00001000/3", s_awaddr, s_awlen); end
    checks++; if (s_wstrb !== 4'hF) begin errors++; $display("FAIL single_wstrb: got %h expected f", s_wstrb); end
    wait_idle(k0 + 1, done_cnt[1], 50, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout: got done=%0d expected %0d", done_cnt[0], k0 + 1); end
    checks++; if ({busy, grant} !== 3'b000) begin errors++; $display("FAIL single_idle_after: got %b expected 000", {busy, grant}); end
    checks++; if (wq.size() - wb !== 4) begin errors++; $display("FAIL single_beat_count: got %0d expected 4", wq.size() - wb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb + i >= wq.size() || wq[wb + i] !== data_of(0, k0, i)) begin errors++; $display("FAIL single_beat%0d: got %h expected %h", i, (wb + i < wq.size()) ? wq[wb + i] : 32'hx, data_of(0, k0, i)); end
    end
    checks++; if (brq.size() != bb + 1 || brq[bb] !== 3'b000) begin errors++; $display("FAIL single_bresp: got %b expected 000 (m0, OKAY)", brq[bb]); end
    checks++; if (gcyc - g0 < 6) begin errors++; $display("FAIL single_grant_cycles: got %0d expected >=6", gcyc - g0); end
    checks++; if (b_wait - bw0 !== 0) begin errors++; $display("FAIL single_b_wait: got %0d expected 0", b_wait - bw0); end
  endtask

  task automatic test_simultaneous();
    int wb, gb, ab, bb, geb, k0, k1; logic ok; logic [31:0] exp;
    pulse_reset();
    @(posedge clk); #2;
    wb = wq.size(); gb = gq.size(); ab = aq.size(); bb = b_edge_q.size(); geb = g_edge_q.size();
    k0 = done_cnt[0]; k1 = done_cnt[1];
    len_cfg[0] = 8'd3; len_cfg[1] = 8'd1; req_cnt[0]++; req_cnt[1]++;
    wait_idle(k0 + 1, k1 + 1, 100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL simul_timeout: got %0d/%0d expected %0d/%0d", done_cnt[0], done_cnt[1], k0 + 1, k1 + 1); end
    checks++; if (gq.size() != gb + 2 || gq[gb] !== 2'b01 || gq[gb + 1] !== 2'b10) begin errors++; $display("FAIL simul_order: got %b,%b expected 01,10", gq[gb], gq[gb + 1]); end
    checks++; if (aq.size() != ab + 2 || aq[ab + 1] !== 32'h2000 + 32'(k1 << 4)) begin errors++; $display("FAIL simul_m1_addr: got %h expected %h", aq[ab + 1], 32'h2000 + 32'(k1 << 4)); end
    checks++;
    if (g_edge_q.size() < geb + 2 || b_edge_q.size() < bb + 1 || g_edge_q[geb + 1] - b_edge_q[bb] !== 2) begin
      errors++; $display("FAIL simul_b2b_gap: got %0d expected 2", g_edge_q[geb + 1] - b_edge_q[bb]);
    end
    for (int i = 0; i < 6; i++) begin
      exp = (i < 4) ? data_of(0, k0, i) : data_of(1, k1, i - 4);
      checks++;
      if (wb + i >= wq.size() || wq[wb + i] !== exp) begin errors++; $display("FAIL simul_beat%0d: got %h expected %h", i, (wb + i < wq.size()) ? wq[wb + i] : 32'hx, exp); end
    end
  endtask

  task automatic test_fairness();
    int gb, k0, k1; logic ok; logic [1:0] exp;
    @(posedge clk); #2;
    gb = gq.size(); k0 = done_cnt[0]; k1 = done_cnt[1];
    len_cfg[0] = 8'd1; len_cfg[1] = 8'd1; req_cnt[0] += 3; req_cnt[1] += 3;
    wait_idle(k0 + 3, k1 + 3, 300, ok);
    checks++; if (ok !== 1'b1 || gq.size() != gb + 6) begin errors++; $display("FAIL fair_count: got %0d grants expected 6", gq.size() - gb); end
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (gb + i >= gq.size() || gq[gb + i] !== exp) begin errors++; $display("FAIL fair_grant%0d: got %b expected %b", i, (gb + i < gq.size()) ? gq[gb + i] : 2'bxx, exp); end
    end
  endtask

  task automatic test_early_w();
    int wb, v0, k0, k1; logic ok; logic [31:0] exp;
    @(posedge clk); #2;
    wb = wq.size(); v0 = viol; k0 = done_cnt[0]; k1 = done_cnt[1];
    early[1] = 1'b1; len_cfg[0] = 8'd3; len_cfg[1] = 8'd3; req_cnt[0]++; req_cnt[1]++;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL early_grant_m0: got %b expected 01", grant); end
    checks++; if ({m_wvalid[1], m_wready[1]} !== 2'b10) begin errors++; $display("FAIL early_m1_wready: got wvalid/wready %b expected 10", {m_wvalid[1], m_wready[1]}); end
    wait_idle(k0 + 1, k1 + 1, 100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL early_timeout: got %0d/%0d expected %0d/%0d", done_cnt[0], done_cnt[1], k0 + 1, k1 + 1); end
    checks++; if (viol - v0 !== 0) begin errors++; $display("FAIL early_wready_leak: got %0d cycles expected 0", viol - v0); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 4) ? data_of(0, k0, i) : data_of(1, k1, i - 4);
      checks++;
      if (wb + i >= wq.size() || wq[wb + i] !== exp) begin errors++; $display("FAIL early_beat%0d: got %h expected %h", i, (wb + i < wq.size()) ? wq[wb + i] : 32'hx, exp); end
    end
    early[1] = 1'b0;
  endtask

  task automatic test_backpressure();
    int wb, bb, ww0, bw0, k0; logic ok;
    @(posedge clk); #2;
    wb = wq.size(); bb = brq.size(); ww0 = w_wait; bw0 = b_wait; k0 = done_cnt[0];
    w_toggle = 1'b1; b_delay = 5; bresp_val = 2'b10; len_cfg[0] = 8'd3; req_cnt[0]++;
    wait_idle(k0 + 1, done_cnt[1], 100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: got %0d expected %0d", done_cnt[0], k0 + 1); end
    checks++; if (wq.size() - wb !== 4) begin errors++; $display("FAIL bp_beat_count: got %0d expected 4", wq.size() - wb); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb + i >= wq.size() || wq[wb + i] !== data_of(0, k0, i)) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", i, (wb + i < wq.size()) ? wq[wb + i] : 32'hx, data_of(0, k0, i)); end
    end
    checks++; if (w_wait - ww0 < 3) begin errors++; $display("FAIL bp_w_stalls: got %0d expected >=3", w_wait - ww0); end
    checks++; if (b_wait - bw0 !== 5) begin errors++; $display("FAIL bp_b_wait: got %0d expected 5", b_wait - bw0); end
    checks++; if (brq.size() != bb + 1 || brq[bb] !== 3'b010) begin errors++; $display("FAIL bp_bresp: got %b expected 010 (m0, SLVERR)", brq[bb]); end
    w_toggle = 1'b0; b_delay = 0; bresp_val = 2'b00;
  endtask

  task automatic test_reset_mid();
    int n, gb, k0, k1; logic ok;
    @(posedge clk); #2;
    len_cfg[0] = 8'd3; req_cnt[0]++;
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!(phase[0] == 1 && beat[0] == 1) && n < 50);
    checks++; if (phase[0] != 1 || beat[0] != 1) begin errors++; $display("FAIL rst_mid_reach: got phase %0d beat %0d expected 1/1", phase[0], beat[0]); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rst_mid_pre_grant: got %b expected 01", grant); end
    ARESETn = 1'b0;
    @(posedge clk); #2;
    checks++; if ({grant, s_wvalid, busy} !== 4'b0000) begin errors++; $display("FAIL rst_mid_outputs: got grant/wvalid/busy %b expected 0000", {grant, s_wvalid, busy}); end
    ARESETn = 1'b1;
    @(posedge clk); #2;
    gb = gq.size(); k0 = done_cnt[0]; k1 = done_cnt[1];
    len_cfg[0] = 8'd1; len_cfg[1] = 8'd1; req_cnt[0]++; req_cnt[1]++;
    wait_idle(k0 + 1, k1 + 1, 100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_mid_timeout: got %0d/%0d expected %0d/%0d", done_cnt[0], done_cnt[1], k0 + 1, k1 + 1); end
    checks++; if (gq.size() != gb + 2 || gq[gb] !== 2'b01 || gq[gb + 1] !== 2'b10) begin errors++; $display("FAIL rst_mid_rearb: got %b,%b expected 01,10", gq[gb], gq[gb + 1]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_early_w();
    test_backpressure();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
